// File: rtl/conv_sequencer_if.sv
// Shared data-memory port used by the convolution sequencer.
// The sequencer is the master; the memory (or arbiter) is the slave.
interface conv_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_gnt,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_gnt,
        output mem_rdata
    );
endinterface

// File: rtl/conv_sequencer.sv
// Offload engine that streams operand pairs through the core ALU's
// convolution op, accumulates per output and writes each sum back.
module conv_sequencer #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] a_stride,
    input  logic [ADDR_W-1:0] b_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [LEN_W-1:0]  len,
    input  logic [LEN_W-1:0]  num_out,
    output logic              busy,
    output logic              done,
    conv_sequencer_if.master  mem,
    output logic [31:0]       alu_a,
    output logic [31:0]       alu_b,
    output logic [2:0]        alu_ctrl,
    input  logic [31:0]       alu_result
);

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        WAIT_A,
        RD_B,
        WAIT_B,
        EXEC,
        WR,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] WORD     = ADDR_W'(4);
    localparam logic [2:0]        ALU_CONV = 3'b111;

    state_t state;
    state_t state_nxt;

    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  num_q;
    logic [LEN_W-1:0]  k;
    logic [LEN_W-1:0]  o;
    logic [ADDR_W-1:0] stride_q;
    logic [ADDR_W-1:0] b_base_q;
    logic [ADDR_W-1:0] a_win;
    logic [ADDR_W-1:0] a_ptr;
    logic [ADDR_W-1:0] b_ptr;
    logic [ADDR_W-1:0] d_ptr;
    logic [31:0]       acc;
    logic [31:0]       a_reg;
    logic [31:0]       b_reg;

    logic cmd_ok;
    logic last_k;
    logic last_o;

    assign cmd_ok = start && (len != '0) && (num_out != '0);
    assign last_k = (k == len_q - LEN_W'(1));
    assign last_o = (o == num_q - LEN_W'(1));

    assign alu_a = a_reg;
    assign alu_b = b_reg;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection; memory states hold until granted.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = cmd_ok ? RD_A : DONE;
                end
            end
            RD_A:   if (mem.mem_gnt) state_nxt = WAIT_A;
            WAIT_A: state_nxt = RD_B;
            RD_B:   if (mem.mem_gnt) state_nxt = WAIT_B;
            WAIT_B: state_nxt = EXEC;
            EXEC:   state_nxt = last_k ? WR : RD_A;
            WR: begin
                if (mem.mem_gnt) begin
                    state_nxt = last_o ? DONE : RD_A;
                end
            end
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state only, so a request stays stable while stalled.
    always_comb begin
        busy          = (state != IDLE);
        done          = 1'b0;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        alu_ctrl      = 3'b000;
        unique case (state)
            RD_A: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = a_ptr;
            end
            RD_B: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = b_ptr;
            end
            EXEC: alu_ctrl = ALU_CONV;
            WR: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = 1'b1;
                mem.mem_addr  = d_ptr;
                mem.mem_wdata = acc;
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: command latch, operand capture, accumulate, pointer walk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q    <= '0;
            num_q    <= '0;
            k        <= '0;
            o        <= '0;
            stride_q <= '0;
            b_base_q <= '0;
            a_win    <= '0;
            a_ptr    <= '0;
            b_ptr    <= '0;
            d_ptr    <= '0;
            acc      <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_ok) begin
                        len_q    <= len;
                        num_q    <= num_out;
                        stride_q <= a_stride;
                        b_base_q <= b_base;
                        a_win    <= a_base;
                        a_ptr    <= a_base;
                        b_ptr    <= b_base;
                        d_ptr    <= dst_base;
                        acc      <= '0;
                        k        <= '0;
                        o        <= '0;
                    end
                end
                WAIT_A: a_reg <= mem.mem_rdata;
                WAIT_B: b_reg <= mem.mem_rdata;
                EXEC: begin
                    acc   <= acc + alu_result;
                    a_ptr <= a_ptr + WORD;
                    b_ptr <= b_ptr + WORD;
                    if (!last_k) begin
                        k <= k + LEN_W'(1);
                    end
                end
                WR: begin
                    if (mem.mem_gnt && !last_o) begin
                        o     <= o + LEN_W'(1);
                        k     <= '0;
                        acc   <= '0;
                        d_ptr <= d_ptr + WORD;
                        a_win <= a_win + stride_q;
                        a_ptr <= a_win + stride_q;
                        b_ptr <= b_base_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer with a memory/ALU stub and a
// transaction scoreboard filled from an independent reference model.
module tb_conv_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a_base;
    logic [31:0] a_stride;
    logic [31:0] b_base;
    logic [31:0] dst_base;
    logic [7:0]  len;
    logic [7:0]  num_out;
    logic        busy;
    logic        done;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_result;

    conv_sequencer_if #(.ADDR_W(32)) bus ();

    conv_sequencer #(.ADDR_W(32), .LEN_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a_base     (a_base),
        .a_stride   (a_stride),
        .b_base     (b_base),
        .dst_base   (dst_base),
        .len        (len),
        .num_out    (num_out),
        .busy       (busy),
        .done       (done),
        .mem        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   t0 = 0;
    int   rel;
    int   busy_cnt;
    int   done_cnt;
    int   done_cyc;
    int   req_cnt;
    int   exec_q[$];
    txn_t sb[$];
    txn_t cur;
    txn_t held;
    txn_t exp_t;
    bit   in_stall;
    bit   mon_en = 1'b0;
    bit   wrap_mode = 1'b0;
    bit   stall_mode = 1'b0;
    int   wcnt;
    logic [31:0] last_wdata;
    logic [31:0] t1_wdata;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_A5A5;
    endfunction

    function automatic logic [31:0] alu_fn(input logic [31:0] x,
                                           input logic [31:0] y);
        return wrap_mode ? 32'hFFFF_FFFF : x * y;
    endfunction

    assign alu_result = alu_fn(alu_a, alu_b);

    assign bus.mem_gnt = bus.mem_req && (!stall_mode || wcnt == 3);

    always @(posedge clk or posedge rst) begin
        if (rst) wcnt <= 0;
        else if (bus.mem_req && !bus.mem_gnt) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    always @(posedge clk) begin
        if (bus.mem_req && bus.mem_gnt && !bus.mem_we)
            bus.mem_rdata <= mem_fn(bus.mem_addr);
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [95:0] obs,
                         input logic [95:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            rel = cyc - t0;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = rel;
            end
            if (alu_ctrl != 3'b000) exec_q.push_back(rel);
            if (bus.mem_req) begin
                req_cnt++;
                cur = '{bus.mem_we, bus.mem_addr, bus.mem_wdata};
                if (in_stall) check("stall_hold", cur, held);
                if (!bus.mem_gnt) begin
                    held = cur;
                    in_stall = 1'b1;
                end else begin
                    in_stall = 1'b0;
                    check("sb_nonempty", 96'(sb.size() > 0), 96'd1);
                    if (sb.size() > 0) begin
                        exp_t = sb.pop_front();
                        check("txn_we", cur.we, exp_t.we);
                        check("txn_addr", cur.addr, exp_t.addr);
                        if (exp_t.we) begin
                            check("txn_wdata", cur.data, exp_t.data);
                            last_wdata = cur.data;
                        end
                    end
                end
            end else begin
                in_stall = 1'b0;
            end
        end
    end

    task automatic clear_mon();
        busy_cnt = 0;
        done_cnt = 0;
        done_cyc = -1;
        req_cnt  = 0;
        in_stall = 1'b0;
        exec_q.delete();
    endtask

    task automatic push_run(input logic [31:0] ab, input logic [31:0] as,
                            input logic [31:0] bb, input logic [31:0] db,
                            input int ln, input int no);
        logic [31:0] acc;
        logic [31:0] aa;
        logic [31:0] ba;
        if (ln == 0 || no == 0) return;
        for (int o = 0; o < no; o++) begin
            acc = 32'h0;
            for (int k = 0; k < ln; k++) begin
                aa = ab + 32'(o) * as + 32'(4 * k);
                ba = bb + 32'(4 * k);
                sb.push_back('{1'b0, aa, 32'h0});
                sb.push_back('{1'b0, ba, 32'h0});
                acc = acc + alu_fn(mem_fn(aa), mem_fn(ba));
            end
            sb.push_back('{1'b1, db + 32'(4 * o), acc});
        end
    endtask

    task automatic launch(input logic [31:0] ab, input logic [31:0] as,
                          input logic [31:0] bb, input logic [31:0] db,
                          input int ln, input int no);
        @(negedge clk);
        #1;
        a_base   = ab;
        a_stride = as;
        b_base   = bb;
        dst_base = db;
        len      = 8'(ln);
        num_out  = 8'(no);
        clear_mon();
        push_run(ab, as, bb, db, ln, no);
        t0 = cyc;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic finish_run(input string tag, input int exp_done,
                              input bit poke_done);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt > 0) break;
        end
        if (done_cnt > 0 && poke_done) begin
            len = 8'd1;
            num_out = 8'd1;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        repeat (2) @(negedge clk);
        #1;
        check({tag, "_done_cyc"}, 96'(done_cyc), 96'(exp_done));
        check({tag, "_done_cnt"}, 96'(done_cnt), 96'd1);
        check({tag, "_busy_cnt"}, 96'(busy_cnt), 96'(exp_done));
        check({tag, "_sb_left"}, 96'(sb.size()), 96'd0);
        if (done_cnt == 0) begin
            rst = 1'b1;
            repeat (2) @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            sb.delete();
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_req"}, bus.mem_req, 1'b0);
        check({tag, "_we"}, bus.mem_we, 1'b0);
        check({tag, "_addr"}, bus.mem_addr, 32'h0);
        check({tag, "_wdata"}, bus.mem_wdata, 32'h0);
        check({tag, "_alu_a"}, alu_a, 32'h0);
        check({tag, "_alu_b"}, alu_b, 32'h0);
        check({tag, "_alu_ctrl"}, alu_ctrl, 3'b000);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        a_base = '0;
        a_stride = '0;
        b_base = '0;
        dst_base = '0;
        len = '0;
        num_out = '0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;

        // Single output, zero wait; start poked during DONE.
        launch(32'h1000, 32'h40, 32'h2000, 32'h3000, 2, 1);
        finish_run("single", 12, 1'b1);
        check("single_exec_n", 96'(exec_q.size()), 96'd2);
        if (exec_q.size() == 2) begin
            check("single_exec0", 96'(exec_q[0]), 96'd5);
            check("single_exec1", 96'(exec_q[1]), 96'd10);
        end
        check("single_reqs", 96'(req_cnt), 96'd5);
        t1_wdata = last_wdata;

        // Several outputs with an A-window stride.
        launch(32'h100, 32'h10, 32'h200, 32'h300, 1, 3);
        finish_run("stride", 19, 1'b0);
        check("stride_exec_n", 96'(exec_q.size()), 96'd3);

        // Three-cycle grant stalls on every request.
        stall_mode = 1'b1;
        launch(32'h1000, 32'h40, 32'h2000, 32'h3000, 2, 1);
        finish_run("stall", 27, 1'b0);
        check("stall_data", last_wdata, t1_wdata);
        stall_mode = 1'b0;

        // Zero length: straight to DONE, no memory traffic.
        launch(32'h1000, 32'h40, 32'h2000, 32'h3000, 0, 4);
        finish_run("zlen", 1, 1'b0);
        check("zlen_reqs", 96'(req_cnt), 96'd0);

        // Accumulator wraps modulo 2^32.
        wrap_mode = 1'b1;
        launch(32'h40, 32'h0, 32'h80, 32'hC0, 2, 1);
        finish_run("wrap", 12, 1'b0);
        check("wrap_data", last_wdata, 32'hFFFF_FFFE);
        wrap_mode = 1'b0;

        // Async reset while RD_B is stalled.
        stall_mode = 1'b1;
        launch(32'h1000, 32'h40, 32'h2000, 32'h3000, 2, 1);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (bus.mem_req && !bus.mem_we && !bus.mem_gnt &&
                bus.mem_addr == 32'h2000) break;
        end
        check("rdb_reached", bus.mem_addr, 32'h2000);
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        check_zero("midrst");
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        stall_mode = 1'b0;
        mon_en = 1'b1;

        // Normal run after reset; a start while busy with other args is ignored.
        launch(32'h500, 32'h8, 32'h600, 32'h700, 2, 2);
        repeat (3) @(negedge clk);
        #1;
        a_base = 32'hDEAD_0000;
        b_base = 32'hBEEF_0000;
        dst_base = 32'hCAFE_0000;
        len = 8'd7;
        num_out = 8'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        finish_run("postrst", 23, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
